twos_comp_serial_ctrl: RTL and testbench

- Bit-serial two's-complement negation engine with a start/busy/done handshake.
- Sequences one WIDTH-bit operand LSB-first through a single-bit negation cell.
- Rule applied per bit: copy bits up to and including the first 1, invert every bit after it.
- Intended as the low-area, sequenced alternative to the parallel combinational negator in the arithmetic section of the design.

---
 rtl/twos_comp_serial_ctrl_pkg.sv | 14 +
 rtl/twos_comp_serial_ctrl_if.sv | 34 +++
 rtl/twos_comp_bit_cell.sv | 18 +
 rtl/twos_comp_serial_ctrl.sv | 112 +++++++++++
 tb/tb_twos_comp_serial_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/twos_comp_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial two's-complement negation engine.
//   - state_t       : controller state encoding (2'd3 is illegal, recovers to IDLE)
//   - DEFAULT_WIDTH : default operand/result width
package twos_comp_serial_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/twos_comp_serial_ctrl_if.sv
// Request/result bundle of the serial negation engine.
//   start    : request, sampled only while the engine is idle
//   in_data  : operand, captured on the accepted start cycle
//   busy     : high while bits are being sequenced
//   done     : one-cycle pulse when out_data becomes valid
//   out_data : negated result, held until the next operation completes
//   ovf      : operand was the most-negative value; held like out_data
//   ser_bit  : result bit produced this cycle, 0 when not sequencing
// The master modport is the requester side, the slave modport the engine.
interface twos_comp_serial_ctrl_if
    import twos_comp_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_data;
    logic             ovf;
    logic             ser_bit;

    modport master (
        output start, in_data,
        input  busy, done, out_data, ovf, ser_bit
    );

    modport slave (
        input  start, in_data,
        output busy, done, out_data, ovf, ser_bit
    );

endinterface

// File: rtl/twos_comp_bit_cell.sv
// Single-bit two's-complement negation cell (combinational).
// Bits are copied up to and including the first 1 seen from the LSB,
// every later bit is inverted.
//   b        : current operand bit
//   seen_in  : a 1 has already been seen in a lower bit
//   r        : negated result bit
//   seen_out : updated "1 seen" flag for the next bit
module twos_comp_bit_cell (
    input  logic b,
    input  logic seen_in,
    output logic r,
    output logic seen_out
);

    assign r        = b ^ seen_in;
    assign seen_out = b | seen_in;

endmodule

// File: rtl/twos_comp_serial_ctrl.sv
// Bit-serial two's-complement negation engine. One WIDTH-bit operand is
// streamed LSB-first through a single negation cell, one bit per clock.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (wins over start)
//   bus   : request/result bundle, slave side (see twos_comp_serial_ctrl_if)
// Timing: start accepted at edge k -> busy for WIDTH cycles -> done pulse in
// the following cycle -> one IDLE cycle before the next start can be taken.
module twos_comp_serial_ctrl
    import twos_comp_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    twos_comp_serial_ctrl_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             seen_one;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] captured;
    logic [WIDTH-1:0] result;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic             ovf_q;

    logic             cell_r;
    logic             cell_seen;
    logic [WIDTH-1:0] result_next;

    twos_comp_bit_cell u_cell (
        .b        (operand[0]),
        .seen_in  (seen_one),
        .r        (cell_r),
        .seen_out (cell_seen)
    );

    // Result fills from the MSB end so that after WIDTH shifts the first
    // produced bit has reached the LSB.
    assign result_next = {cell_r, result[WIDTH-1:1]};

    assign bus.ser_bit  = (state == SHIFT) ? cell_r : 1'b0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out_data = out_q;
    assign bus.ovf      = ovf_q;

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the shift chain and the FSM update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            seen_one <= 1'b0;
            operand  <= '0;
            captured <= '0;
            result   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        operand  <= bus.in_data;
                        captured <= bus.in_data;
                        result   <= '0;
                        counter  <= '0;
                        seen_one <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    operand  <= operand >> 1;
                    result   <= result_next;
                    seen_one <= cell_seen;
                    if (counter == LAST_CNT) begin
                        // Publish the completed word in the same edge that
                        // enters DONE so out_data and done rise together.
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        out_q  <= result_next;
                        // Only the most-negative value negates to itself
                        // with the sign bit set (zero also maps to itself).
                        ovf_q  <= (result_next == captured) && result_next[WIDTH-1];
                        state  <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twos_comp_serial_ctrl.sv
// Self-checking bench for twos_comp_serial_ctrl at WIDTH=4: table of
// operand/expected-result vectors plus hand-written corner sequences.
module tb_twos_comp_serial_ctrl;

    localparam int W = 4;

    logic clk;
    logic reset;

    twos_comp_serial_ctrl_if #(.WIDTH(W)) bus_if ();

    twos_comp_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    logic [W-1:0] prev_out;
    logic         prev_ovf;

    typedef struct {
        logic [W-1:0] opnd;
        logic [W-1:0] exp_out;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation starting from IDLE: checks every SHIFT cycle, the
    // done cycle and the return to IDLE.
    task automatic run_op(input logic [W-1:0] opnd, input logic [W-1:0] exp_out,
                          input logic exp_ovf, input string tag);
        bus_if.start   = 1'b1;
        bus_if.in_data = opnd;
        step();
        bus_if.start   = 1'b0;
        bus_if.in_data = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check($sformatf("%s busy[%0d]", tag, i), 32'(bus_if.busy), 32'd1);
            check($sformatf("%s done[%0d]", tag, i), 32'(bus_if.done), 32'd0);
            check($sformatf("%s ser[%0d]", tag, i), 32'(bus_if.ser_bit), 32'(exp_out[i]));
            check($sformatf("%s hold_out[%0d]", tag, i), 32'(bus_if.out_data), 32'(prev_out));
            check($sformatf("%s hold_ovf[%0d]", tag, i), 32'(bus_if.ovf), 32'(prev_ovf));
            bus_if.in_data = W'($urandom);
            step();
        end
        check({tag, " done"}, 32'(bus_if.done), 32'd1);
        check({tag, " busy_in_done"}, 32'(bus_if.busy), 32'd0);
        check({tag, " ser_in_done"}, 32'(bus_if.ser_bit), 32'd0);
        check({tag, " out"}, 32'(bus_if.out_data), 32'(exp_out));
        check({tag, " ovf"}, 32'(bus_if.ovf), 32'(exp_ovf));
        step();
        check({tag, " done_pulse"}, 32'(bus_if.done), 32'd0);
        check({tag, " busy_idle"}, 32'(bus_if.busy), 32'd0);
        check({tag, " out_held"}, 32'(bus_if.out_data), 32'(exp_out));
        prev_out = exp_out;
        prev_ovf = exp_ovf;
    endtask

    initial begin
        int done_cnt;
        int done_cyc[$];

        total = 0;
        bad   = 0;
        prev_out = '0;
        prev_ovf = 1'b0;

        vecs[0] = '{4'b0101, 4'b1011, 1'b0};
        vecs[1] = '{4'b0000, 4'b0000, 1'b0};
        vecs[2] = '{4'b1000, 4'b1000, 1'b1};
        vecs[3] = '{4'b1111, 4'b0001, 1'b0};
        vecs[4] = '{4'b0001, 4'b1111, 1'b0};
        vecs[5] = '{4'b0111, 4'b1001, 1'b0};
        vecs[6] = '{4'b0110, 4'b1010, 1'b0};
        vecs[7] = '{4'b1001, 4'b0111, 1'b0};
        vecs[8] = '{4'b0100, 4'b1100, 1'b0};

        // Reset with start asserted: reset must win.
        reset          = 1'b1;
        bus_if.start   = 1'b1;
        bus_if.in_data = 4'b0101;
        step();
        step();
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset done", 32'(bus_if.done), 32'd0);
        check("reset out", 32'(bus_if.out_data), 32'd0);
        check("reset ovf", 32'(bus_if.ovf), 32'd0);
        check("reset ser", 32'(bus_if.ser_bit), 32'd0);
        bus_if.start = 1'b0;
        reset        = 1'b0;
        step();
        check("idle busy", 32'(bus_if.busy), 32'd0);

        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].opnd, vecs[v].exp_out, vecs[v].exp_ovf, $sformatf("vec%0d", v));
        end

        // start pulses during SHIFT and DONE are ignored.
        bus_if.start   = 1'b1;
        bus_if.in_data = 4'b0011;
        step();
        bus_if.in_data = 4'b0110;
        done_cnt = 0;
        for (int i = 0; i < W + 1; i++) begin
            if (bus_if.done) done_cnt++;
            step();
        end
        // Now one cycle after DONE, in IDLE; drop start before its edge.
        bus_if.start = 1'b0;
        check("ign done_count", 32'(done_cnt), 32'd1);
        check("ign out", 32'(bus_if.out_data), 32'b1101);
        check("ign ovf", 32'(bus_if.ovf), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ign no_busy[%0d]", i), 32'(bus_if.busy), 32'd0);
            check($sformatf("ign no_done[%0d]", i), 32'(bus_if.done), 32'd0);
        end
        prev_out = 4'b1101;
        prev_ovf = 1'b0;

        // Reset in the second SHIFT cycle discards the operation.
        bus_if.start   = 1'b1;
        bus_if.in_data = 4'b0111;
        step();
        bus_if.start = 1'b0;
        check("rst first_shift busy", 32'(bus_if.busy), 32'd1);
        step();
        check("rst second_shift busy", 32'(bus_if.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst busy", 32'(bus_if.busy), 32'd0);
        check("rst out", 32'(bus_if.out_data), 32'd0);
        check("rst ovf", 32'(bus_if.ovf), 32'd0);
        check("rst ser", 32'(bus_if.ser_bit), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (bus_if.done || bus_if.busy) done_cnt++;
            step();
        end
        check("rst no_activity", 32'(done_cnt), 32'd0);
        prev_out = '0;
        prev_ovf = 1'b0;
        run_op(4'b0001, 4'b1111, 1'b0, "after_rst");

        // Back-to-back: start held high, operations every W+2 cycles.
        bus_if.start   = 1'b1;
        bus_if.in_data = 4'b0010;
        for (int c = 1; c <= 3 * (W + 2); c++) begin
            step();
            if (bus_if.done) begin
                done_cyc.push_back(c);
                check($sformatf("b2b out@%0d", c), 32'(bus_if.out_data), 32'b1110);
                check($sformatf("b2b ovf@%0d", c), 32'(bus_if.ovf), 32'd0);
            end
        end
        bus_if.start = 1'b0;
        check("b2b done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            check("b2b first_done", 32'(done_cyc[0]), 32'(W + 1));
            check("b2b period1", 32'(done_cyc[1] - done_cyc[0]), 32'(W + 2));
            check("b2b period2", 32'(done_cyc[2] - done_cyc[1]), 32'(W + 2));
        end
        for (int i = 0; i < W + 3; i++) step();
        check("drain busy", 32'(bus_if.busy), 32'd0);
        check("drain out", 32'(bus_if.out_data), 32'b1110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
